// File: rtl/pwm4_pkg.sv
// Shared constants and types for the 4-bit PWM compare block.
package pwm4_pkg;

  // Default upstream count width and wrap-counter width.
  localparam int WIDTH_DEFAULT = 4;
  localparam int NWRAP_DEFAULT = 8;

  // Duty value at the default width.
  typedef logic [WIDTH_DEFAULT-1:0] duty_t;

  // A wrap is a terminal-count carry seen while generation is enabled.
  function automatic logic is_wrap(input logic en, input logic cout);
    return en & cout;
  endfunction

endpackage

// File: rtl/pwm4_duty_buf.sv
// One-entry pending buffer for duty values waiting for a period boundary.
// ready depends only on the full flag, never on the producer's valid.
import pwm4_pkg::*;

module pwm4_duty_buf #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             ready
);

  // Capture on push into an empty slot, release on pop; reset discards content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      full <= 1'b0;
    end else if (push && !full) begin
      q    <= data;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  assign ready = ~full;

endmodule

// File: rtl/pwm4_compare.sv
// PWM generator comparing an upstream count against the active duty value.
// Duty updates are taken through a valid/ready port and only become active
// at a wrap (terminal count while enabled), so every change lands on a
// period boundary.
//
// Handshake: a transfer happens on a rising edge where duty_valid and
// duty_ready are both 1; duty_data is ignored on every other edge. The
// producer may drop or change duty_valid/duty_data freely; offering a value
// while duty_ready is low sets the sticky late flag.
import pwm4_pkg::*;

module pwm4_compare #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NWRAP = NWRAP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic             cout,
  input  logic [WIDTH-1:0] duty_data,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm,
  output logic [WIDTH-1:0] duty_act,
  output logic             wrap_pulse,
  output logic [NWRAP-1:0] wraps,
  output logic             late
);

  logic             wrap;
  logic             hs;
  logic             buf_push;
  logic             buf_pop;
  logic             buf_full;
  logic [WIDTH-1:0] buf_q;

  assign wrap     = is_wrap(en, cout);
  assign hs       = duty_valid & duty_ready;
  // Off a wrap an accepted value waits in the buffer; on a wrap it goes
  // straight to the active register (the buffer is empty whenever hs is 1).
  assign buf_push = hs & ~wrap;
  assign buf_pop  = wrap & buf_full;

  pwm4_duty_buf #(
    .WIDTH(WIDTH)
  ) u_duty_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .pop   (buf_pop),
    .data  (duty_data),
    .q     (buf_q),
    .full  (buf_full),
    .ready (duty_ready)
  );

  // Active duty only moves at a wrap: pending value first, else a same-edge handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act <= '0;
    end else if (wrap) begin
      if (buf_full) begin
        duty_act <= buf_q;
      end else if (hs) begin
        duty_act <= duty_data;
      end
    end
  end

  // Registered compare against the duty value in force before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en & (cnt < duty_act);
    end
  end

  // Wrap count (modulo 2^NWRAP) and one-cycle wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wraps      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= wrap;
      if (wrap) begin
        wraps <= wraps + NWRAP'(1);
      end
    end
  end

  // Sticky flag: a value was offered while the pending slot was still occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      late <= 1'b0;
    end else if (duty_valid && !duty_ready) begin
      late <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm4_compare.sv
// Bench for pwm4_compare: scenario tasks driving cnt/cout/duty stimulus,
// with per-cycle pwm and wrap_pulse expectations queued as stimulus is driven.
`timescale 1ns/1ps

module tb_pwm4_compare;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] cnt;
  logic       cout;
  logic [3:0] duty_data;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm;
  logic [3:0] duty_act;
  logic       wrap_pulse;
  logic [7:0] wraps;
  logic       late;

  logic       n_duty_ready;
  logic       n_pwm;
  logic [3:0] n_duty_act;
  logic       n_wrap_pulse;
  logic [1:0] n_wraps;
  logic       n_late;

  int total = 0;
  int bad   = 0;
  int exp_act   = 0;
  int exp_wraps = 0;
  logic [0:0] exp_q[$];
  logic [0:0] wp_q[$];

  pwm4_compare #(.WIDTH(4), .NWRAP(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cnt        (cnt),
    .cout       (cout),
    .duty_data  (duty_data),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm        (pwm),
    .duty_act   (duty_act),
    .wrap_pulse (wrap_pulse),
    .wraps      (wraps),
    .late       (late)
  );

  pwm4_compare #(.WIDTH(4), .NWRAP(2)) dut_n (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cnt        (cnt),
    .cout       (cout),
    .duty_data  (duty_data),
    .duty_valid (duty_valid),
    .duty_ready (n_duty_ready),
    .pwm        (n_pwm),
    .duty_act   (n_duty_act),
    .wrap_pulse (n_wrap_pulse),
    .wraps      (n_wraps),
    .late       (n_late)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  // Driver: apply one cycle of inputs and queue the expected pwm/wrap_pulse.
  task automatic drive(input logic e, input int c, input logic v, input logic [3:0] d);
    en         = e;
    cnt        = c[3:0];
    cout       = (c == 15);
    duty_valid = v;
    duty_data  = d;
    exp_q.push_back(e && (c < exp_act));
    wp_q.push_back(e && (c == 15));
    if (e && c == 15) exp_wraps++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cnt = '0; cout = 1'b0;
    duty_valid = 1'b0; duty_data = '0;
    repeat (2) @(posedge clk);
    #1;
    total += 6;
    if (pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm got %b want 0", pwm); end
    if (duty_act !== 4'd0) begin bad++; $display("FAIL reset_duty_act got %0d want 0", duty_act); end
    if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL reset_wrap_pulse got %b want 0", wrap_pulse); end
    if (wraps !== 8'd0) begin bad++; $display("FAIL reset_wraps got %0d want 0", wraps); end
    if (late !== 1'b0) begin bad++; $display("FAIL reset_late got %b want 0", late); end
    if (duty_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", duty_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_duty();
    logic [0:0] ep, ew;
    exp_act = 0;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, c, 1'b0, 4'd0);
      ep = exp_q.pop_front(); ew = wp_q.pop_front();
      total += 2;
      if (pwm !== ep) begin bad++; $display("FAIL zero_pwm c=%0d got %b want %b", c, pwm, ep); end
      if (wrap_pulse !== ew) begin bad++; $display("FAIL zero_wrap_pulse c=%0d got %b want %b", c, wrap_pulse, ew); end
    end
    total++;
    if (wraps !== 8'(exp_wraps)) begin bad++; $display("FAIL zero_wraps got %0d want %0d", wraps, exp_wraps); end
  endtask

  task automatic test_handshake_pending();
    logic [0:0] ep, ew;
    int highs;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, c, (c == 3), 4'd5);
      ep = exp_q.pop_front(); ew = wp_q.pop_front();
      total += 4;
      if (pwm !== ep) begin bad++; $display("FAIL pend_pwm c=%0d got %b want %b", c, pwm, ep); end
      if (wrap_pulse !== ew) begin bad++; $display("FAIL pend_wrap_pulse c=%0d got %b want %b", c, wrap_pulse, ew); end
      if (duty_ready !== !(c >= 3 && c < 15)) begin bad++; $display("FAIL pend_ready c=%0d got %b want %b", c, duty_ready, !(c >= 3 && c < 15)); end
      if (duty_act !== ((c == 15) ? 4'd5 : 4'd0)) begin bad++; $display("FAIL pend_duty_act c=%0d got %0d want %0d", c, duty_act, (c == 15) ? 5 : 0); end
    end
    exp_act = 5;
    highs = 0;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, c, 1'b0, 4'd0);
      ep = exp_q.pop_front(); ew = wp_q.pop_front();
      total += 2;
      if (pwm !== ep) begin bad++; $display("FAIL duty5_pwm c=%0d got %b want %b", c, pwm, ep); end
      if (wrap_pulse !== ew) begin bad++; $display("FAIL duty5_wrap_pulse c=%0d got %b want %b", c, wrap_pulse, ew); end
      if (pwm === 1'b1) highs++;
    end
    total++;
    if (highs != 5) begin bad++; $display("FAIL duty5_high_count got %0d want 5", highs); end
  endtask

  task automatic test_direct_load();
    logic [0:0] ep;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, c, (c == 15), 4'd9);
      ep = exp_q.pop_front(); void'(wp_q.pop_front());
      total += 3;
      if (pwm !== ep) begin bad++; $display("FAIL direct_pwm c=%0d got %b want %b", c, pwm, ep); end
      if (duty_ready !== 1'b1) begin bad++; $display("FAIL direct_ready c=%0d got %b want 1", c, duty_ready); end
      if (duty_act !== ((c == 15) ? 4'd9 : 4'd5)) begin bad++; $display("FAIL direct_duty_act c=%0d got %0d want %0d", c, duty_act, (c == 15) ? 9 : 5); end
    end
    exp_act = 9;
  endtask

  task automatic test_late();
    logic [0:0] ep;
    total++;
    if (late !== 1'b0) begin bad++; $display("FAIL late_initial got %b want 0", late); end
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, c, (c == 2) || (c >= 5), (c == 2) ? 4'd7 : 4'd12);
      ep = exp_q.pop_front(); void'(wp_q.pop_front());
      total += 4;
      if (pwm !== ep) begin bad++; $display("FAIL late_pwm c=%0d got %b want %b", c, pwm, ep); end
      if (duty_ready !== !(c >= 2 && c < 15)) begin bad++; $display("FAIL late_ready c=%0d got %b want %b", c, duty_ready, !(c >= 2 && c < 15)); end
      if (late !== (c >= 5)) begin bad++; $display("FAIL late_flag c=%0d got %b want %b", c, late, (c >= 5)); end
      if (duty_act !== ((c == 15) ? 4'd7 : 4'd9)) begin bad++; $display("FAIL late_duty_act c=%0d got %0d want %0d", c, duty_act, (c == 15) ? 7 : 9); end
    end
    exp_act = 7;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, c, (c == 0), 4'd12);
      ep = exp_q.pop_front(); void'(wp_q.pop_front());
      total += 4;
      if (pwm !== ep) begin bad++; $display("FAIL late2_pwm c=%0d got %b want %b", c, pwm, ep); end
      if (duty_ready !== (c == 15)) begin bad++; $display("FAIL late2_ready c=%0d got %b want %b", c, duty_ready, (c == 15)); end
      if (late !== 1'b1) begin bad++; $display("FAIL late2_flag c=%0d got %b want 1", c, late); end
      if (duty_act !== ((c == 15) ? 4'd12 : 4'd7)) begin bad++; $display("FAIL late2_duty_act c=%0d got %0d want %0d", c, duty_act, (c == 15) ? 12 : 7); end
    end
    exp_act = 12;
  endtask

  task automatic test_en_low();
    logic [0:0] ep, ew;
    drive(1'b1, 3, 1'b0, 4'd0);
    ep = exp_q.pop_front(); void'(wp_q.pop_front());
    total++;
    if (pwm !== ep) begin bad++; $display("FAIL en_pwm_on got %b want %b", pwm, ep); end
    drive(1'b0, 3, 1'b0, 4'd0);
    ep = exp_q.pop_front(); void'(wp_q.pop_front());
    total++;
    if (pwm !== ep) begin bad++; $display("FAIL en_pwm_off got %b want %b", pwm, ep); end
    drive(1'b0, 15, 1'b1, 4'd6);
    ep = exp_q.pop_front(); ew = wp_q.pop_front();
    total += 5;
    if (pwm !== ep) begin bad++; $display("FAIL en_off_cout_pwm got %b want %b", pwm, ep); end
    if (wrap_pulse !== ew) begin bad++; $display("FAIL en_off_wrap_pulse got %b want %b", wrap_pulse, ew); end
    if (wraps !== 8'(exp_wraps)) begin bad++; $display("FAIL en_off_wraps got %0d want %0d", wraps, exp_wraps); end
    if (duty_ready !== 1'b0) begin bad++; $display("FAIL en_off_ready got %b want 0", duty_ready); end
    if (duty_act !== 4'd12) begin bad++; $display("FAIL en_off_duty_act got %0d want 12", duty_act); end
    drive(1'b1, 15, 1'b0, 4'd0);
    ep = exp_q.pop_front(); ew = wp_q.pop_front();
    total += 4;
    if (wrap_pulse !== ew) begin bad++; $display("FAIL en_on_wrap_pulse got %b want %b", wrap_pulse, ew); end
    if (wraps !== 8'(exp_wraps)) begin bad++; $display("FAIL en_on_wraps got %0d want %0d", wraps, exp_wraps); end
    if (duty_ready !== 1'b1) begin bad++; $display("FAIL en_on_ready got %b want 1", duty_ready); end
    if (duty_act !== 4'd6) begin bad++; $display("FAIL en_on_duty_act got %0d want 6", duty_act); end
    exp_act = 6;
    drive(1'b1, 5, 1'b0, 4'd0);
    ep = exp_q.pop_front(); void'(wp_q.pop_front());
    total++;
    if (pwm !== ep) begin bad++; $display("FAIL en_duty6_pwm got %b want %b", pwm, ep); end
  endtask

  task automatic test_reset_mid();
    logic [0:0] ep;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, c, (c == 2), 4'd4);
      ep = exp_q.pop_front(); void'(wp_q.pop_front());
      total++;
      if (pwm !== ep) begin bad++; $display("FAIL mid_pwm c=%0d got %b want %b", c, pwm, ep); end
    end
    total++;
    if (duty_ready !== 1'b0) begin bad++; $display("FAIL mid_pending_ready got %b want 0", duty_ready); end
    rst_n = 1'b0;
    #2;
    total += 7;
    if (pwm !== 1'b0) begin bad++; $display("FAIL mid_rst_pwm got %b want 0", pwm); end
    if (duty_act !== 4'd0) begin bad++; $display("FAIL mid_rst_duty_act got %0d want 0", duty_act); end
    if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_wrap_pulse got %b want 0", wrap_pulse); end
    if (wraps !== 8'd0) begin bad++; $display("FAIL mid_rst_wraps got %0d want 0", wraps); end
    if (late !== 1'b0) begin bad++; $display("FAIL mid_rst_late got %b want 0", late); end
    if (duty_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got %b want 1", duty_ready); end
    if (n_wraps !== 2'd0) begin bad++; $display("FAIL mid_rst_narrow_wraps got %0d want 0", n_wraps); end
    #1;
    rst_n = 1'b1;
    exp_act = 0;
    exp_wraps = 0;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, c, 1'b0, 4'd0);
      ep = exp_q.pop_front(); void'(wp_q.pop_front());
      total += 2;
      if (pwm !== ep) begin bad++; $display("FAIL post_rst_pwm c=%0d got %b want %b", c, pwm, ep); end
      if (duty_act !== 4'd0) begin bad++; $display("FAIL post_rst_duty_act c=%0d got %0d want 0", c, duty_act); end
    end
    total++;
    if (wraps !== 8'(exp_wraps)) begin bad++; $display("FAIL post_rst_wraps got %0d want %0d", wraps, exp_wraps); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [5];
    logic [0:0] ep, ew;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_act = 0;
    exp_wraps = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 15, 1'b0, 4'd0);
      ep = exp_q.pop_front(); ew = wp_q.pop_front();
      total += 4;
      if (n_wraps !== seq[i]) begin bad++; $display("FAIL b2b_narrow_wraps i=%0d got %0d want %0d", i, n_wraps, seq[i]); end
      if (wraps !== 8'(exp_wraps)) begin bad++; $display("FAIL b2b_wraps i=%0d got %0d want %0d", i, wraps, exp_wraps); end
      if (wrap_pulse !== ew) begin bad++; $display("FAIL b2b_wrap_pulse i=%0d got %b want %b", i, wrap_pulse, ew); end
      if (pwm !== ep) begin bad++; $display("FAIL b2b_pwm i=%0d got %b want %b", i, pwm, ep); end
    end
    drive(1'b1, 0, 1'b0, 4'd0);
    void'(exp_q.pop_front()); ew = wp_q.pop_front();
    total += 2;
    if (wrap_pulse !== ew) begin bad++; $display("FAIL b2b_pulse_end got %b want %b", wrap_pulse, ew); end
    if (n_wraps !== 2'd1) begin bad++; $display("FAIL b2b_narrow_hold got %0d want 1", n_wraps); end
  endtask

  initial begin
    test_reset();
    test_zero_duty();
    test_handshake_pending();
    test_direct_load();
    test_late();
    test_en_low();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm4_compare.md
PWM4_COMPARE -- requirements
Module: pwm4_compare

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the upstream count width.
REQ-002 The block SHALL have parameter NWRAP, default 8, giving the wrap-counter width.
REQ-003 CLK  in  1  Sole clock; all state changes on its rising edge.
REQ-004 RESETN  in  1  Reset; asynchronous assert, active-low.
REQ-005 EN  in  1  Enables PWM generation and wrap counting.
REQ-006 CNT  in  WIDTH  Count value from the upstream free-running counter.
REQ-007 COUT  in  1  Upstream carry; high in the cycle CNT equals all-ones (terminal count).
REQ-008 DUTY_DATA  in  WIDTH  New duty value.
REQ-009 DUTY_VALID  in  1  DUTY_DATA is valid.
REQ-010 DUTY_READY  out  1  Block can accept a duty value.
REQ-011 PWM  out  1  Registered PWM output.
REQ-012 DUTY_ACT  out  WIDTH  Duty value currently in force.
REQ-013 WRAP_PULSE  out  1  Registered one-cycle pulse per counted wrap.
REQ-014 WRAPS  out  NWRAP  Count of wraps since reset, modulo 2^NWRAP.
REQ-015 LATE  out  1  Sticky flag: a duty value waited for a wrap while a newer one was offered.

Function
REQ-016 A wrap event SHALL be defined as COUT=1 and EN=1 sampled on the same rising edge.
REQ-017 A handshake SHALL complete on an edge where DUTY_VALID=1 and DUTY_READY=1.
REQ-018 Data transfer SHALL occur on handshake only; DUTY_DATA is ignored otherwise.
REQ-019 A one-entry pending buffer SHALL hold accepted duty values.
REQ-020 DUTY_READY SHALL equal NOT pending_full, so it is combinational from state only.
REQ-021 On a wrap with the pending buffer full, the pending value SHALL move to DUTY_ACT and the buffer SHALL empty.
REQ-022 On a handshake coinciding with a wrap while the buffer is empty, DUTY_DATA SHALL go directly to DUTY_ACT.
- The buffer stays empty in this case.
REQ-023 On a handshake without a wrap, the value SHALL enter the pending buffer.
REQ-024 DUTY_ACT SHALL never change except at a wrap event, so duty changes are glitch-free period boundaries.
REQ-025 PWM(t+1) SHALL equal EN(t) AND (CNT(t) < DUTY_ACT(t)), compared unsigned.
- Latency is 1 cycle.
- Duty 0 gives constant low.
- Duty 2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
REQ-026 PWM SHALL evaluate on the DUTY_ACT value before any update on the same edge.
REQ-027 WRAPS SHALL increment by 1 on each wrap event and wrap from all-ones to 0 with no flag.
REQ-028 WRAP_PULSE SHALL be 1 in the cycle after each wrap event and 0 otherwise.
REQ-029 LATE SHALL set when DUTY_VALID=1 while DUTY_READY=0, and SHALL clear only on reset.
REQ-030 With EN=0: PWM→0 next cycle, no wrap events occur, the handshake still operates, DUTY_ACT holds.

Reset
REQ-031 While RESETN=0, all registers SHALL be cleared immediately, independent of CLK, with these output values:
- PWM=0, DUTY_ACT=0, WRAP_PULSE=0, WRAPS=0, LATE=0.
- Pending buffer empty, so DUTY_READY=1.
REQ-032 Reset asserted mid-period SHALL discard any pending duty value.
REQ-033 The first edge after RESETN rises SHALL behave as a normal cycle.

Structure
REQ-034 Package pwm4_pkg SHALL hold the WIDTH and NWRAP default constants and a duty_t typedef (logic [WIDTH-1:0]).
REQ-035 The pending buffer SHALL be sub-module pwm4_duty_buf, owning storage, the full flag and DUTY_READY.
- Inputs: push, pop, data.
REQ-036 The compare, wrap counting and LATE logic SHALL reside in pwm4_compare.
REQ-037 No latches and no combinational path from DUTY_VALID to DUTY_READY SHALL exist.

Verification
REQ-038 Reset, EN=1, DUTY_ACT=0, drive CNT 0..15 with COUT at 15 -> PWM stays 0, WRAPS=1 and WRAP_PULSE high for one cycle after CNT=15.
REQ-039 Handshake duty=5 at CNT=3 -> DUTY_READY=0 until wrap, then DUTY_ACT=5; following period PWM high exactly 5 cycles, one cycle after CNT=0..4.
REQ-040 Handshake duty=9 in the same cycle as COUT=1 with buffer empty -> DUTY_ACT=9 after that edge, DUTY_READY stays 1.
REQ-041 Buffer holding 7, DUTY_VALID=1 with 12 before the wrap -> 12 not accepted, LATE=1; after the wrap DUTY_ACT=7, then 12 is accepted.
REQ-042 RESETN pulsed low mid-period with 4 pending -> all outputs 0 without a clock edge, DUTY_READY=1, and 4 never becomes active.
REQ-043 NWRAP=2 with 5 wraps -> WRAPS sequence 1,2,3,0,1.
